wb_stage: RTL and testbench



---
 rtl/wb_pkg.sv | 39 +++
 rtl/wb_stage_cp0.sv | 99 +++++++++
 rtl/wb_stage.sv | 80 ++++++++
 tb/tb_wb_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: cp0 ops, HI/LO write modes,
// CP0 register numbers and exception constants.
package wb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PCW  = 30;

  localparam logic [2:0] CP0_NONE    = 3'd0;
  localparam logic [2:0] CP0_MFC0    = 3'd1;
  localparam logic [2:0] CP0_MTC0    = 3'd2;
  localparam logic [2:0] CP0_SYSCALL = 3'd3;
  localparam logic [2:0] CP0_ERET    = 3'd4;

  localparam logic [1:0] MUL_NONE = 2'b00;
  localparam logic [1:0] MUL_HI   = 2'b01;
  localparam logic [1:0] MUL_LO   = 2'b10;
  localparam logic [1:0] MUL_BOTH = 2'b11;

  localparam logic [4:0] CP0_COUNT  = 5'd9;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_SYS    = 5'd8;
  localparam int unsigned STATUS_EXL = 1;

  localparam logic [XLEN-1:0] EXC_VEC_DEFAULT = 32'h0000_4180;

  typedef enum logic {
    MODE_USER   = 1'b0,
    MODE_KERNEL = 1'b1
  } mode_e;

  // Cause layout: IP[1:0] at [9:8], ExcCode at [6:2], everything else zero.
  function automatic logic [XLEN-1:0] cause_word(input logic [1:0] ip, input logic [4:0] exc);
    return {22'd0, ip, 1'b0, exc, 2'b00};
  endfunction

endpackage

// File: rtl/wb_stage_cp0.sv
// Minimal CP0: Count, Status, Cause, EPC, the mfc0 read mux and the
// syscall/eret handling, including the registered fetch redirect.
module cp0_regs
  import wb_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VEC = EXC_VEC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      cp0_op,
  input  logic [4:0]      cs,
  input  logic [2:0]      sel,
  input  logic [XLEN-1:0] busb,
  input  logic [PCW-1:0]  pc,
  output logic [XLEN-1:0] rdata_c,
  output logic            redirect_valid,
  output logic [PCW-1:0]  redirect_pc,
  output logic            status_exl
);

  mode_e           mode_q, mode_d;
  logic [XLEN-1:0] count_q;
  logic [XLEN-1:2] status_hi_q;
  logic            status_b0_q;
  logic [1:0]      cause_ip_q;
  logic [4:0]      cause_exc_q;
  logic [PCW-1:0]  epc_q;

  logic is_sys, is_eret, is_mtc0;
  logic wr_count, wr_status, wr_cause, wr_epc;

  assign is_sys    = (cp0_op == CP0_SYSCALL);
  assign is_eret   = (cp0_op == CP0_ERET);
  assign is_mtc0   = (cp0_op == CP0_MTC0) && (sel == 3'd0);
  assign wr_count  = is_mtc0 && (cs == CP0_COUNT);
  assign wr_status = is_mtc0 && (cs == CP0_STATUS);
  assign wr_cause  = is_mtc0 && (cs == CP0_CAUSE);
  assign wr_epc    = is_mtc0 && (cs == CP0_EPC);

  // Status.EXL is the mode state itself; it is not stored a second time.
  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_USER;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_q == MODE_USER) begin
      if (is_sys || (wr_status && busb[STATUS_EXL])) mode_d = MODE_KERNEL;
    end else begin
      if (is_eret || (wr_status && !busb[STATUS_EXL])) mode_d = MODE_USER;
    end
  end

  assign status_exl = (mode_q == MODE_KERNEL);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q        <= '0;
      status_hi_q    <= '0;
      status_b0_q    <= 1'b0;
      cause_ip_q     <= '0;
      cause_exc_q    <= '0;
      epc_q          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      count_q <= wr_count ? busb : count_q + 32'd1;
      if (wr_status) begin
        status_hi_q <= busb[XLEN-1:2];
        status_b0_q <= busb[0];
      end
      if (wr_cause) cause_ip_q <= busb[9:8];
      if (wr_epc)   epc_q      <= busb[XLEN-1:2];
      if (is_sys) begin
        // A nested syscall keeps the original return address.
        if (mode_q == MODE_USER) epc_q <= pc;
        cause_exc_q <= EXC_SYS;
      end
      redirect_valid <= is_sys || is_eret;
      if (is_sys)       redirect_pc <= EXC_VEC[XLEN-1:2];
      else if (is_eret) redirect_pc <= epc_q;
    end
  end

  always_comb begin
    rdata_c = '0;
    if (sel == 3'd0) begin
      case (cs)
        CP0_COUNT:  rdata_c = count_q;
        CP0_STATUS: rdata_c = {status_hi_q, status_exl, status_b0_q};
        CP0_CAUSE:  rdata_c = cause_word(cause_ip_q, cause_exc_q);
        CP0_EPC:    rdata_c = {epc_q, 2'b00};
        default:    rdata_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: GPR write port, HI/LO multiply registers and the
// CP0 block that issues syscall/eret redirects.
module wb_stage
  import wb_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VEC = EXC_VEC_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [XLEN-1:0] wr_dout,
  input  logic [XLEN-1:0] wr_alu_result,
  input  logic [4:0]      wr_Rw,
  input  logic            wr_RegWr,
  input  logic            wr_MemtoReg,
  input  logic [XLEN-1:0] wr_busA,
  input  logic [63:0]     wr_mul_result,
  input  logic [1:0]      wr_regToMul,
  input  logic            wr_mulToReg,
  input  logic            wr_mulRead,
  input  logic [4:0]      wr_cs,
  input  logic [2:0]      wr_sel,
  input  logic [XLEN-1:0] wr_busB,
  input  logic [2:0]      wr_cp0Op,
  input  logic [PCW-1:0]  wr_PC,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            redirect_valid,
  output logic [PCW-1:0]  redirect_pc,
  output logic            status_exl
);

  logic [XLEN-1:0] hi_q, lo_q;
  logic [XLEN-1:0] cp0_rdata_c;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      case (wr_regToMul)
        MUL_HI:   hi_q <= wr_busA;
        MUL_LO:   lo_q <= wr_busA;
        MUL_BOTH: begin
          hi_q <= wr_mul_result[63:32];
          lo_q <= wr_mul_result[31:0];
        end
        default:  ;
      endcase
    end
  end

  cp0_regs #(.EXC_VEC(EXC_VEC)) u_cp0 (
    .clk            (Clk),
    .reset          (Reset),
    .cp0_op         (wr_cp0Op),
    .cs             (wr_cs),
    .sel            (wr_sel),
    .busb           (wr_busB),
    .pc             (wr_PC),
    .rdata_c        (cp0_rdata_c),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .status_exl     (status_exl)
  );

  // mtc0, syscall and eret never write a GPR even if RegWr is set.
  assign rf_we = wr_RegWr && (wr_Rw != 5'd0) &&
                 !((wr_cp0Op == CP0_MTC0) || (wr_cp0Op == CP0_SYSCALL) ||
                   (wr_cp0Op == CP0_ERET));
  assign rf_waddr = wr_Rw;

  always_comb begin
    rf_wdata = wr_alu_result;
    if (wr_cp0Op == CP0_MFC0)  rf_wdata = cp0_rdata_c;
    else if (wr_mulToReg)      rf_wdata = wr_mulRead ? hi_q : lo_q;
    else if (wr_MemtoReg)      rf_wdata = wr_dout;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a table of combinational GPR-port vectors
// plus directed sequences for HI/LO, CP0, syscall/eret and reset corners.
module tb_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] wr_dout, wr_alu_result, wr_busA, wr_busB;
  logic [4:0]  wr_Rw, wr_cs;
  logic        wr_RegWr, wr_MemtoReg, wr_mulToReg, wr_mulRead;
  logic [63:0] wr_mul_result;
  logic [1:0]  wr_regToMul;
  logic [2:0]  wr_sel, wr_cp0Op;
  logic [29:0] wr_PC;
  logic        rf_we, redirect_valid, status_exl;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [29:0] redirect_pc;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  wb_stage dut (
    .Clk(Clk), .Reset(Reset),
    .wr_dout(wr_dout), .wr_alu_result(wr_alu_result), .wr_Rw(wr_Rw),
    .wr_RegWr(wr_RegWr), .wr_MemtoReg(wr_MemtoReg), .wr_busA(wr_busA),
    .wr_mul_result(wr_mul_result), .wr_regToMul(wr_regToMul),
    .wr_mulToReg(wr_mulToReg), .wr_mulRead(wr_mulRead), .wr_cs(wr_cs),
    .wr_sel(wr_sel), .wr_busB(wr_busB), .wr_cp0Op(wr_cp0Op), .wr_PC(wr_PC),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .status_exl(status_exl)
  );

  typedef struct {
    logic        regwr;
    logic [4:0]  rw;
    logic        memtoreg;
    logic [31:0] dout;
    logic [31:0] alu;
    logic [2:0]  cp0op;
    logic [4:0]  cs;
    logic [2:0]  sel;
    logic [31:0] busb;
    logic        multoreg;
    logic        mulread;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [0:9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    wr_dout = '0; wr_alu_result = '0; wr_busA = '0; wr_busB = '0;
    wr_Rw = '0; wr_cs = '0; wr_RegWr = 0; wr_MemtoReg = 0;
    wr_mulToReg = 0; wr_mulRead = 0; wr_mul_result = '0;
    wr_regToMul = '0; wr_sel = '0; wr_cp0Op = '0; wr_PC = '0;
  endtask

  task automatic mfc0(input logic [4:0] cs);
    idle();
    wr_cp0Op = 3'd1; wr_cs = cs; wr_RegWr = 1; wr_Rw = 5'd2;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] cs, input logic [31:0] val);
    idle();
    wr_cp0Op = 3'd2; wr_cs = cs; wr_busB = val;
  endtask

  initial begin
    // {regwr, rw, memtoreg, dout, alu, cp0op, cs, sel, busb, multoreg, mulread, exp_we, exp_wdata}
    vecs[0] = '{1, 5'd0,  0, 32'h0,  32'h5,         3'd0, 5'd0,  3'd0, 32'h0,    0, 0, 0, 32'h5};
    vecs[1] = '{1, 5'd7,  1, 32'hAA, 32'h5,         3'd0, 5'd0,  3'd0, 32'h0,    0, 0, 1, 32'hAA};
    vecs[2] = '{1, 5'd31, 0, 32'h0,  32'h1234_5678, 3'd0, 5'd0,  3'd0, 32'h0,    0, 0, 1, 32'h1234_5678};
    vecs[3] = '{0, 5'd4,  0, 32'h0,  32'h9,         3'd0, 5'd0,  3'd0, 32'h0,    0, 0, 0, 32'h9};
    vecs[4] = '{1, 5'd8,  0, 32'h0,  32'h77,        3'd2, 5'd0,  3'd0, 32'hDEAD, 0, 0, 0, 32'h77};
    vecs[5] = '{1, 5'd8,  0, 32'h0,  32'h66,        3'd5, 5'd0,  3'd0, 32'h0,    0, 0, 1, 32'h66};
    vecs[6] = '{1, 5'd9,  1, 32'hBB, 32'h11,        3'd1, 5'd5,  3'd0, 32'h0,    0, 0, 1, 32'h0};
    vecs[7] = '{1, 5'd9,  0, 32'h0,  32'h11,        3'd1, 5'd9,  3'd1, 32'h0,    0, 0, 1, 32'h0};
    vecs[8] = '{1, 5'd10, 1, 32'hCC, 32'h3,         3'd0, 5'd0,  3'd0, 32'h0,    1, 1, 1, 32'h0};
    vecs[9] = '{1, 5'd10, 0, 32'h0,  32'h3,         3'd1, 5'd12, 3'd0, 32'h0,    1, 0, 1, 32'h0};

    idle();
    Reset = 1;
    repeat (2) @(negedge Clk);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    chk("rst_status_exl", 32'(status_exl), 32'd0);
    mfc0(5'd9);  chk("rst_count", rf_wdata, 32'd0);
    chk("rst_mfc0_we", 32'(rf_we), 32'd1);
    mfc0(5'd12); chk("rst_status", rf_wdata, 32'd0);
    idle(); wr_mulToReg = 1; wr_mulRead = 1; #1;
    chk("rst_hi", rf_wdata, 32'd0);

    // Count after reset release, then mtc0 Count wrap
    idle();
    Reset = 0;
    repeat (3) @(negedge Clk);
    mfc0(5'd9); chk("count_after_release", rf_wdata, 32'd3);
    mtc0(5'd9, 32'hFFFF_FFFF);
    @(negedge Clk);
    mfc0(5'd9); chk("count_written", rf_wdata, 32'hFFFF_FFFF);
    @(negedge Clk);
    mfc0(5'd9); chk("count_wrap", rf_wdata, 32'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      idle();
      wr_RegWr = vecs[i].regwr; wr_Rw = vecs[i].rw; wr_MemtoReg = vecs[i].memtoreg;
      wr_dout = vecs[i].dout; wr_alu_result = vecs[i].alu; wr_cp0Op = vecs[i].cp0op;
      wr_cs = vecs[i].cs; wr_sel = vecs[i].sel; wr_busB = vecs[i].busb;
      wr_mulToReg = vecs[i].multoreg; wr_mulRead = vecs[i].mulread;
      #1;
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].rw));
      chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
    end

    // HI/LO: full product, then mthi (with pre-edge read), then mtlo
    @(negedge Clk);
    idle(); wr_regToMul = 2'b11; wr_mul_result = 64'h0000_0001_FFFF_FFFE;
    @(negedge Clk);
    idle(); wr_mulToReg = 1; wr_mulRead = 1; wr_Rw = 5'd3; wr_RegWr = 1; #1;
    chk("mul_hi", rf_wdata, 32'd1);
    chk("mul_we", 32'(rf_we), 32'd1);
    chk("mul_waddr", 32'(rf_waddr), 32'd3);
    wr_mulRead = 0; #1;
    chk("mul_lo", rf_wdata, 32'hFFFF_FFFE);
    @(negedge Clk);
    idle(); wr_regToMul = 2'b01; wr_busA = 32'hCAFE; wr_mulToReg = 1; wr_mulRead = 1; #1;
    chk("mthi_pre_edge", rf_wdata, 32'd1);
    @(negedge Clk);
    idle(); wr_regToMul = 2'b10; wr_busA = 32'hBEEF; wr_mulToReg = 1; wr_mulRead = 1; #1;
    chk("mthi_hi", rf_wdata, 32'hCAFE);
    @(negedge Clk);
    idle(); wr_mulToReg = 1; wr_mulRead = 0; #1;
    chk("mtlo_lo", rf_wdata, 32'hBEEF);
    wr_mulRead = 1; #1;
    chk("mtlo_hi_kept", rf_wdata, 32'hCAFE);

    // syscall from user mode
    @(negedge Clk);
    idle(); wr_cp0Op = 3'd3; wr_PC = 30'h0000_0C05; wr_RegWr = 1; wr_Rw = 5'd5; #1;
    chk("sys_no_we", 32'(rf_we), 32'd0);
    @(negedge Clk);
    chk("sys_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("sys_redirect_pc", 32'(redirect_pc), 32'h0000_1060);
    chk("sys_exl", 32'(status_exl), 32'd1);
    mfc0(5'd14); chk("sys_epc", rf_wdata, 32'h0000_3014);
    @(negedge Clk);
    chk("sys_redirect_drop", 32'(redirect_valid), 32'd0);
    mfc0(5'd13); chk("sys_cause", rf_wdata, 32'h0000_0020);
    mfc0(5'd12); chk("sys_status", rf_wdata, 32'h0000_0002);

    // nested syscall keeps EPC, then eret returns to it
    idle(); wr_cp0Op = 3'd3; wr_PC = 30'h0000_3100;
    @(negedge Clk);
    chk("sys2_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("sys2_redirect_pc", 32'(redirect_pc), 32'h0000_1060);
    mfc0(5'd14); chk("sys2_epc_kept", rf_wdata, 32'h0000_3014);
    idle(); wr_cp0Op = 3'd4;
    @(negedge Clk);
    chk("eret_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("eret_redirect_pc", 32'(redirect_pc), 30'h0000_0C05);
    chk("eret_exl", 32'(status_exl), 32'd0);
    idle();
    @(negedge Clk);
    chk("eret_redirect_drop", 32'(redirect_valid), 32'd0);

    // mtc0 Status/Cause/EPC and eret to a written EPC
    mtc0(5'd12, 32'h0000_0002);
    @(negedge Clk);
    chk("mtc0_exl_set", 32'(status_exl), 32'd1);
    mtc0(5'd12, 32'h0000_0000);
    @(negedge Clk);
    chk("mtc0_exl_clr", 32'(status_exl), 32'd0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    @(negedge Clk);
    mfc0(5'd13); chk("mtc0_cause", rf_wdata, 32'h0000_0320);
    mtc0(5'd14, 32'h1234_567F);
    @(negedge Clk);
    mfc0(5'd14); chk("mtc0_epc", rf_wdata, 32'h1234_567C);
    idle(); wr_cp0Op = 3'd4;
    @(negedge Clk);
    chk("eret2_redirect_pc", 32'(redirect_pc), 32'h048D_159F);
    idle(); wr_cp0Op = 3'd2; wr_cs = 5'd12; wr_sel = 3'd1; wr_busB = 32'h2;
    @(negedge Clk);
    chk("mtc0_sel1_ignored", 32'(status_exl), 32'd0);

    // reset in the syscall cycle
    idle(); Reset = 1; wr_cp0Op = 3'd3; wr_PC = 30'h0000_0555;
    @(negedge Clk);
    chk("rstsys_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rstsys_exl", 32'(status_exl), 32'd0);
    Reset = 0;
    mfc0(5'd14); chk("rstsys_epc", rf_wdata, 32'd0);
    @(negedge Clk);
    chk("rstsys_redirect_valid2", 32'(redirect_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
